// File: rtl/obuf_pkg.sv
// Shared definitions for the output-buffer stream writer.
//   DATA_W : width of one input beat
//   LANES  : beats packed into one buffer word
//   WORD_W : buffer word width (DATA_W * LANES)
//   ADDR_W : buffer address width (64K words)
//   LANE_W : width of the lane index
//   state_e: writer control states
package obuf_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int WORD_W = DATA_W * LANES;
    localparam int ADDR_W = 16;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

endpackage

// File: rtl/obuf_lane_packer.sv
// Packs consecutive DATA_W beats into one WORD_W word. Lane 0 lands in the
// least significant bits. The final lane is not stored: the completed word
// is presented combinationally in the cycle that final beat is accepted, so
// the top level can register it straight into the buffer write port.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : restart packing at lane 0 (new command)
//   beat_valid     : a beat transfers this cycle
//   beat_data      : beat payload
//   word_valid     : this beat completes a word
//   word_data      : the completed word (valid with word_valid)
module obuf_lane_packer
    import obuf_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              beat_valid,
    input  logic [DATA_W-1:0] beat_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [WORD_W-DATA_W-1:0] asm_q, asm_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        lane_d = lane_q;
        asm_d  = asm_q;
        if (clear) begin
            lane_d = '0;
        end else if (beat_valid) begin
            lane_d = lane_q + LANE_W'(1);
            for (int k = 0; k < LANES - 1; k++) begin
                if (lane_q == LANE_W'(k)) begin
                    asm_d[k*DATA_W +: DATA_W] = beat_data;
                end
            end
        end
    end

    assign word_valid = beat_valid && !clear && (lane_q == LANE_W'(LANES - 1));
    assign word_data  = {beat_data, asm_q};

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value regardless of block ordering.
    // NOTE: the assembly register is reset too; it is small, and a partial
    // word abandoned by reset then never carries stale lanes in simulation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

endmodule

// File: rtl/obuf_stream_writer.sv
// Write-side controller for the 64K x 128-bit 1R1W output buffer. Takes a
// command (base address, word count), accepts 4*word_count 32-bit beats over
// valid/ready, packs them into 128-bit words and drives the buffer write port
// from registers. Addresses wrap modulo 2^ADDR_W.
// Optional feature: define OBUF_WR_CHECKSUM_EN to add the `checksum` output,
// the running XOR of every word written for the current command.
// Ports:
//   clock, reset_n       : clock and asynchronous active-low reset
//   start                : command strobe, honoured only when idle
//   base_addr            : first buffer address of the command
//   word_count           : words to write, 0..65536
//   in_valid/in_data     : beat stream input
//   in_ready             : beat accept (high only while running)
//   mem_we/mem_waddr/mem_wdata : buffer write port (registered, held when idle)
//   busy                 : command in progress
//   done                 : one-cycle completion pulse
//   words_written        : words committed for the current command
//   checksum             : (OBUF_WR_CHECKSUM_EN only) XOR of written words
module obuf_stream_writer
    import obuf_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
`ifdef OBUF_WR_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0] checksum
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   ww_q, ww_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start_acc;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;

    // Any start seen while idle is a command; a zero count completes at once.
    assign start_acc = (state_q == IDLE) && start;

    obuf_lane_packer u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (start_acc),
        .beat_valid (in_valid && in_ready_q),
        .beat_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        ww_d        = ww_q;
        in_ready_d  = in_ready_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ww_d = '0;
                    if (word_count != '0) begin
                        state_d    = RUN;
                        ptr_d      = base_addr;
                        rem_d      = word_count;
                        in_ready_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = ptr_q;
                    mem_wdata_d = word_data;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    ww_d        = ww_q + (ADDR_W+1)'(1);
                    rem_d       = rem_q - (ADDR_W+1)'(1);
                    // Last word: its write cycle doubles as the FLUSH cycle.
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d    = FLUSH;
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            ww_q        <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            ww_q        <= ww_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_we        = mem_we_q;
    assign mem_waddr     = mem_waddr_q;
    assign mem_wdata     = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_written = ww_q;

`ifdef OBUF_WR_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q, csum_d;

    // Folded in alongside the write-port register so the value already
    // includes the last word during the done cycle.
    always_comb begin
        csum_d = csum_q;
        if (start_acc) begin
            csum_d = '0;
        end else if (mem_we_d) begin
            csum_d = csum_q ^ mem_wdata_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_obuf_stream_writer.sv
module tb_obuf_stream_writer;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [15:0]   base_addr;
    logic [16:0]   word_count;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          mem_we;
    logic [15:0]   mem_waddr;
    logic [127:0]  mem_wdata;
    logic          busy;
    logic          done;
    logic [16:0]   words_written;
`ifdef OBUF_WR_CHECKSUM_EN
    logic [127:0]  checksum;
`endif

    obuf_stream_writer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
`ifdef OBUF_WR_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks a command as "beats taken so far out of 4*count"; each fourth
    // beat yields a word at base + (beats/4 - 1) modulo 64K.
    bit           m_active = 0;
    bit           m_flush  = 0;
    logic [15:0]  m_base   = '0;
    int           m_total  = 0;
    int           m_taken  = 0;
    logic [127:0] m_acc    = '0;
    logic [127:0] m_csum   = '0;
    bit           exp_we = 0, exp_done = 0, exp_busy = 0, exp_ready = 0;
    logic [15:0]  exp_addr = '0;
    logic [127:0] exp_data = '0;
    logic [16:0]  exp_ww   = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_flush = 0; m_taken = 0; m_csum = '0;
            exp_we = 0; exp_done = 0; exp_busy = 0; exp_ready = 0;
            exp_addr = '0; exp_data = '0; exp_ww = '0;
        end else begin
            exp_we   = 0;
            exp_done = 0;
            if (m_flush) begin
                m_flush = 0;
            end else if (!m_active) begin
                if (start) begin
                    exp_ww = '0;
                    m_csum = '0;
                    if (word_count == 17'd0) begin
                        exp_done = 1;
                    end else begin
                        m_active  = 1;
                        m_base    = base_addr;
                        m_total   = int'(word_count) * 4;
                        m_taken   = 0;
                        exp_ready = 1;
                    end
                end
            end else if (in_valid) begin
                m_acc[(m_taken % 4) * 32 +: 32] = in_data;
                m_taken++;
                if (m_taken % 4 == 0) begin
                    exp_we   = 1;
                    exp_addr = 16'(int'(m_base) + m_taken / 4 - 1);
                    exp_data = m_acc;
                    exp_ww   = 17'(m_taken / 4);
                    m_csum   = m_csum ^ m_acc;
                    if (m_taken == m_total) begin
                        m_active  = 0;
                        m_flush   = 1;
                        exp_done  = 1;
                        exp_ready = 0;
                    end
                end
            end
            exp_busy = m_active || m_flush;
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    logic [15:0]  wr_addr[$];
    logic [127:0] wr_data[$];
    bit           wr_done[$];
    int           done_cnt = 0;
    logic [16:0]  done_ww  = '0;
    logic [127:0] done_csum = '0;

    always @(negedge clock) begin
        check("in_ready", 128'(in_ready), 128'(exp_ready));
        check("mem_we", 128'(mem_we), 128'(exp_we));
        check("mem_waddr", 128'(mem_waddr), 128'(exp_addr));
        check("mem_wdata", mem_wdata, exp_data);
        check("busy", 128'(busy), 128'(exp_busy));
        check("done", 128'(done), 128'(exp_done));
        check("words_written", 128'(words_written), 128'(exp_ww));
`ifdef OBUF_WR_CHECKSUM_EN
        if (exp_done || !exp_busy) check("checksum", checksum, m_csum);
`endif
        if (mem_we) begin
            wr_addr.push_back(mem_waddr);
            wr_data.push_back(mem_wdata);
            wr_done.push_back(done);
        end
        if (done) begin
            done_cnt++;
            done_ww = words_written;
`ifdef OBUF_WR_CHECKSUM_EN
            done_csum = checksum;
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] beat_q[$];
    int          ignore_at = -1;

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_done.delete();
        done_cnt = 0;
    endtask

    task automatic issue_start(input logic [15:0] b, input logic [16:0] c);
        start = 1'b1; base_addr = b; word_count = c;
        @(posedge clock); #1;
        start = 1'b0; base_addr = $urandom; word_count = 17'($urandom);
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random valid
    task automatic feed(input int n, input int mode);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < n * 4 + 40) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_data    = (beat_q.size() > 0) ? beat_q[0] : $urandom;
            start      = (cyc == ignore_at);
            base_addr  = 16'h0300;
            word_count = 17'd5;
            @(negedge clock);
            if (in_valid && in_ready) begin
                sent++;
                if (beat_q.size() > 0) void'(beat_q.pop_front());
            end
            @(posedge clock); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("feed_complete", 128'(sent), 128'(n));
    endtask

    task automatic junk(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_we", 128'(mem_we), 128'(0));
        check("rst_waddr", 128'(mem_waddr), 128'(0));
        check("rst_wdata", mem_wdata, 128'(0));
        check("rst_ready", 128'(in_ready), 128'(0));
        reset_n = 1'b1;
        settle();

        // Single word
        clear_log();
        beat_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        issue_start(16'h0010, 17'd1);
        feed(4, 0);
        settle();
        check("t1_nwrites", 128'(wr_addr.size()), 128'(1));
        if (wr_addr.size() == 1) begin
            check("t1_addr", 128'(wr_addr[0]), 128'h0010);
            check("t1_data", wr_data[0], 128'h44444444_33333333_22222222_11111111);
            check("t1_done_same_cycle", 128'(wr_done[0]), 128'(1));
        end
        check("t1_done_cnt", 128'(done_cnt), 128'(1));
        check("t1_ww", 128'(done_ww), 128'(1));

        // Throughput with stalls
        clear_log();
        beat_q.delete();
        for (int w = 0; w < 3; w++)
            for (int l = 0; l < 4; l++) beat_q.push_back(32'(w * 256 + l));
        issue_start(16'h0100, 17'd3);
        feed(12, 1);
        settle();
        check("t2_nwrites", 128'(wr_addr.size()), 128'(3));
        if (wr_addr.size() == 3) begin
            check("t2_addr0", 128'(wr_addr[0]), 128'h0100);
            check("t2_addr1", 128'(wr_addr[1]), 128'h0101);
            check("t2_addr2", 128'(wr_addr[2]), 128'h0102);
            check("t2_data1", wr_data[1], 128'h00000103_00000102_00000101_00000100);
        end

        // Address wrap
        clear_log();
        issue_start(16'hFFFE, 17'd4);
        feed(16, 2);
        settle();
        check("t3_nwrites", 128'(wr_addr.size()), 128'(4));
        if (wr_addr.size() == 4) begin
            check("t3_addr0", 128'(wr_addr[0]), 128'hFFFE);
            check("t3_addr1", 128'(wr_addr[1]), 128'hFFFF);
            check("t3_addr2", 128'(wr_addr[2]), 128'h0000);
            check("t3_addr3", 128'(wr_addr[3]), 128'h0001);
        end
        check("t3_ww", 128'(done_ww), 128'(4));

        // Zero-count command
        clear_log();
        junk(3);
        issue_start(16'h1234, 17'd0);
        settle();
        check("t4_zero_done", 128'(done_cnt), 128'(1));
        check("t4_zero_nwrites", 128'(wr_addr.size()), 128'(0));

        // Start during RUN is ignored
        clear_log();
        ignore_at = 3;
        issue_start(16'h0200, 17'd2);
        feed(8, 0);
        ignore_at = -1;
        settle();
        check("t5_nwrites", 128'(wr_addr.size()), 128'(2));
        if (wr_addr.size() == 2) begin
            check("t5_addr0", 128'(wr_addr[0]), 128'h0200);
            check("t5_addr1", 128'(wr_addr[1]), 128'h0201);
        end
        check("t5_done_cnt", 128'(done_cnt), 128'(1));

        // Reset mid-command after 6 beats
        clear_log();
        issue_start(16'h0400, 17'd2);
        feed(6, 0);
        in_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_we", 128'(mem_we), 128'(0));
        check("t6_rst_busy", 128'(busy), 128'(0));
        check("t6_rst_ready", 128'(in_ready), 128'(0));
        check("t6_rst_ww", 128'(words_written), 128'(0));
        check("t6_rst_waddr", 128'(mem_waddr), 128'(0));
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        settle();
        check("t6_nwrites", 128'(wr_addr.size()), 128'(1));
        if (wr_addr.size() == 1) check("t6_addr0", 128'(wr_addr[0]), 128'h0400);
        check("t6_no_done", 128'(done_cnt), 128'(0));

`ifdef OBUF_WR_CHECKSUM_EN
        // Checksum of two words 0x...01 and 0x...03
        clear_log();
        beat_q = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h3, 32'h0, 32'h0, 32'h0};
        issue_start(16'h0500, 17'd2);
        feed(8, 0);
        settle();
        check("t7_checksum", done_csum, 128'h2);
`endif

        // Randomised commands, including idle junk and a post-reset restart
        for (int r = 0; r < 6; r++) begin
            int cnt;
            cnt = $urandom_range(1, 5);
            junk($urandom_range(0, 2));
            clear_log();
            issue_start(16'($urandom), 17'(cnt));
            feed(cnt * 4, 2);
            settle();
            check("rnd_nwrites", 128'(wr_addr.size()), 128'(cnt));
            check("rnd_done_cnt", 128'(done_cnt), 128'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
